// File: rtl/mipsenc_pkg.sv
// MIPS instruction encoder shared types: mnemonics, opcode/funct codes, field positions.
// The enc_r/enc_i/enc_j helpers assemble one 32-bit word from fields that have already been masked.
package mipsenc_pkg;

  typedef enum logic [4:0] {
    ADD, SUB, AND, OR, SLT, MFHI, MFLO, JR,
    LW, SW, BEQ, BNE, ADDI, J, JAL, SLTI, LB, SB
  } mnem_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_MFHI = 6'b010000;
  localparam logic [5:0] FN_MFLO = 6'b010010;
  localparam logic [5:0] FN_JR   = 6'b001000;

  localparam int OP_POS = 26;
  localparam int RS_POS = 21;
  localparam int RT_POS = 16;
  localparam int RD_POS = 11;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
  } enc_entry_t;

  // shamt is always zero for the supported R-type set.
  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] funct);
    return (32'(OP_RTYPE) << OP_POS) | (32'(rs) << RS_POS) | (32'(rt) << RT_POS) |
           (32'(rd) << RD_POS) | 32'(funct);
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return (32'(op) << OP_POS) | (32'(rs) << RS_POS) | (32'(rt) << RT_POS) | 32'(imm);
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] target);
    return (32'(op) << OP_POS) | 32'(target);
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Field-level instruction input and encoded-word output of instr_encoder.
// mnem is carried as raw 5 bits so out-of-range codes can reach the encoder.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  mnem;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm;
  logic [25:0] target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic [31:0] addr;
  logic        err;

  modport master (
    output in_valid, mnem, rs, rt, rd, imm, target, out_ready,
    input  in_ready, out_valid, instr, addr, err
  );

  modport slave (
    input  in_valid, mnem, rs, rt, rd, imm, target, out_ready,
    output in_ready, out_valid, instr, addr, err
  );
endinterface

// File: rtl/enc_fifo.sv
// 2-entry FIFO of {instr, addr}; push visible at the head one cycle later.
// Push is ignored when full and pop when empty; clear empties it synchronously.
module enc_fifo
  import mipsenc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       push,
  input  logic       pop,
  input  enc_entry_t wdata,
  output enc_entry_t rdata,
  output logic [1:0] count
);
  enc_entry_t mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic       do_push;
  logic       do_pop;

  assign do_push = push && (count != 2'd2);
  assign do_pop  = pop && (count != 2'd0);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end

  // Storage needs no reset: its contents are only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push && !(reset || clear)) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
endmodule

// File: rtl/instr_encoder.sv
// Encodes MIPS mnemonics/fields into 32-bit words and buffers them with their address (2-deep, 1-cycle latency).
// INSTR_ENCODER_BYTE_OPS_EN enables LB/SB; without it they are rejected like any unsupported mnemonic.
module instr_encoder
  import mipsenc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  instr_encoder_if.slave bus
);
  logic [31:0] word;
  logic [31:0] addr_cnt;
  logic        supported;
  logic        accept;
  logic        push;
  logic        pop;
  logic        err_q;
  logic [1:0]  count;
  enc_entry_t  head;

  always_comb begin
    word      = '0;
    supported = 1'b1;
    case (mnem_t'(bus.mnem))
      ADD:  word = enc_r(bus.rs, bus.rt, bus.rd, FN_ADD);
      SUB:  word = enc_r(bus.rs, bus.rt, bus.rd, FN_SUB);
      AND:  word = enc_r(bus.rs, bus.rt, bus.rd, FN_AND);
      OR:   word = enc_r(bus.rs, bus.rt, bus.rd, FN_OR);
      SLT:  word = enc_r(bus.rs, bus.rt, bus.rd, FN_SLT);
      MFHI: word = enc_r(5'd0, 5'd0, bus.rd, FN_MFHI);
      MFLO: word = enc_r(5'd0, 5'd0, bus.rd, FN_MFLO);
      JR:   word = enc_r(bus.rs, 5'd0, 5'd0, FN_JR);
      LW:   word = enc_i(OP_LW, bus.rs, bus.rt, bus.imm);
      SW:   word = enc_i(OP_SW, bus.rs, bus.rt, bus.imm);
      BEQ:  word = enc_i(OP_BEQ, bus.rs, bus.rt, bus.imm);
      BNE:  word = enc_i(OP_BNE, bus.rs, bus.rt, bus.imm);
      ADDI: word = enc_i(OP_ADDI, bus.rs, bus.rt, bus.imm);
      SLTI: word = enc_i(OP_SLTI, bus.rs, bus.rt, bus.imm);
      J:    word = enc_j(OP_J, bus.target);
      JAL:  word = enc_j(OP_JAL, bus.target);
`ifdef INSTR_ENCODER_BYTE_OPS_EN
      LB:   word = enc_i(OP_LB, bus.rs, bus.rt, bus.imm);
      SB:   word = enc_i(OP_SB, bus.rs, bus.rt, bus.imm);
`endif
      default: supported = 1'b0;
    endcase
  end

  assign bus.in_ready = (count < 2'd2) && !flush;
  assign accept       = bus.in_valid && bus.in_ready;
  assign push         = accept && supported;
  assign pop          = bus.out_valid && bus.out_ready && !flush;

  // Unsupported words are consumed from the input but never take an address.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      addr_cnt <= BASE_ADDR;
      err_q    <= 1'b0;
    end else begin
      if (push) addr_cnt <= addr_cnt + 32'd4;
      if (accept && !supported) err_q <= 1'b1;
    end
  end

  enc_fifo u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .push  (push),
    .pop   (pop),
    .wdata ('{instr: word, addr: addr_cnt}),
    .rdata (head),
    .count (count)
  );

  assign bus.out_valid = (count != 2'd0);
  assign bus.instr     = bus.out_valid ? head.instr : 32'd0;
  assign bus.addr      = bus.out_valid ? head.addr : addr_cnt;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_instr_encoder.sv
// Randomized and directed bench for instr_encoder against a queue-based reference model.
module tb_instr_encoder;
  import mipsenc_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, flush, reset2, flush2;
  instr_encoder_if bus ();
  instr_encoder_if bus2 ();

  instr_encoder dut (.clk(clk), .reset(reset), .flush(flush), .bus(bus));
  instr_encoder #(.BASE_ADDR(32'hFFFF_FFFC)) dut2 (.clk(clk), .reset(reset2), .flush(flush2), .bus(bus2));

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_cnt;
  logic        m_err;
  bit          m_known = 0;

  // Reference encoder: table of format/opcode/funct per mnemonic index, assembled arithmetically.
  function automatic bit ref_encode(input logic [4:0] m, input logic [4:0] rs, input logic [4:0] rt,
                                    input logic [4:0] rd, input logic [15:0] imm,
                                    input logic [25:0] tgt, output logic [31:0] w);
    longint op, fn, v;
    int kind;
    op = 0; fn = 0; kind = -1; w = 32'd0;
    case (m)
      5'd0:  begin kind = 0; fn = 32; end
      5'd1:  begin kind = 0; fn = 34; end
      5'd2:  begin kind = 0; fn = 36; end
      5'd3:  begin kind = 0; fn = 37; end
      5'd4:  begin kind = 0; fn = 42; end
      5'd5:  begin kind = 1; fn = 16; end
      5'd6:  begin kind = 1; fn = 18; end
      5'd7:  begin kind = 2; fn = 8; end
      5'd8:  begin kind = 3; op = 35; end
      5'd9:  begin kind = 3; op = 43; end
      5'd10: begin kind = 3; op = 4; end
      5'd11: begin kind = 3; op = 5; end
      5'd12: begin kind = 3; op = 8; end
      5'd13: begin kind = 4; op = 2; end
      5'd14: begin kind = 4; op = 3; end
      5'd15: begin kind = 3; op = 10; end
`ifdef INSTR_ENCODER_BYTE_OPS_EN
      5'd16: begin kind = 3; op = 32; end
      5'd17: begin kind = 3; op = 40; end
`endif
      default: kind = -1;
    endcase
    case (kind)
      0: v = longint'(rs) * 2097152 + longint'(rt) * 65536 + longint'(rd) * 2048 + fn;
      1: v = longint'(rd) * 2048 + fn;
      2: v = longint'(rs) * 2097152 + fn;
      3: v = op * 67108864 + longint'(rs) * 2097152 + longint'(rt) * 65536 + longint'(imm);
      4: v = op * 67108864 + longint'(tgt);
      default: v = 0;
    endcase
    w = 32'(v);
    return kind >= 0;
  endfunction

  // One clock: drive at negedge, advance model at posedge, compare at next negedge.
  task automatic step(input bit v, input logic [4:0] m, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
                      input bit ordy, input bit fl, input bit rst);
    bit acc, pop, sup;
    logic [31:0] w;
    bus.in_valid = v; bus.mnem = m; bus.rs = rs; bus.rt = rt; bus.rd = rd;
    bus.imm = imm; bus.target = tgt; bus.out_ready = ordy; flush = fl; reset = rst;
    #1;
    if (m_known) check_eq("in_ready", 32'(bus.in_ready), 32'(q.size() < 2 && !fl));
    acc = v && q.size() < 2 && !fl;
    pop = q.size() > 0 && ordy;
    sup = ref_encode(m, rs, rt, rd, imm, tgt, w);
    @(posedge clk);
    if (rst || fl) begin
      q.delete(); m_cnt = 32'd0; m_err = 1'b0; m_known = 1;
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) begin
        if (sup) begin q.push_back('{w, m_cnt}); m_cnt = m_cnt + 32'd4; end
        else m_err = 1'b1;
      end
    end
    @(negedge clk);
    if (m_known) begin
      check_eq("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
      check_eq("err", 32'(bus.err), 32'(m_err));
      if (q.size() > 0) begin
        check_eq("instr", bus.instr, q[0].instr);
        check_eq("addr", bus.addr, q[0].addr);
      end
    end
  endtask

  task automatic idle(input bit ordy);
    step(0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, ordy, 0, 0);
  endtask

  task automatic send(input logic [4:0] m, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
                      input bit ordy);
    step(1, m, rs, rt, rd, imm, tgt, ordy, 0, 0);
  endtask

  task automatic do_reset();
    step(0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 0, 0, 1);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; reset2 = 1'b1; flush2 = 1'b0;
    bus.in_valid = 0; bus.mnem = 0; bus.rs = 0; bus.rt = 0; bus.rd = 0;
    bus.imm = 0; bus.target = 0; bus.out_ready = 0;
    bus2.in_valid = 0; bus2.mnem = 0; bus2.rs = 0; bus2.rt = 0; bus2.rd = 0;
    bus2.imm = 0; bus2.target = 0; bus2.out_ready = 0;
    @(negedge clk);

    do_reset();
    check_eq("rst_instr", bus.instr, 32'h0);
    check_eq("rst_addr", bus.addr, 32'h0);
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);

    send(ADD, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1);
    check_eq("add_word", bus.instr, 32'h0022_1820);
    check_eq("add_addr", bus.addr, 32'h0);
    idle(1);

    do_reset();
    send(LW, 5'd29, 5'd8, 5'd0, 16'h0004, 26'd0, 1);
    check_eq("lw_word", bus.instr, 32'h8FA8_0004);
    send(BEQ, 5'd4, 5'd5, 5'd0, 16'hFFFF, 26'd0, 1);
    check_eq("beq_word", bus.instr, 32'h1085_FFFF);
    check_eq("beq_addr", bus.addr, 32'h4);
    idle(1);

    do_reset();
    send(J, 5'd0, 5'd0, 5'd0, 16'd0, 26'h10, 0);
    send(JAL, 5'd0, 5'd0, 5'd0, 16'd0, 26'h3FF_FFFF, 0);
    check_eq("full_in_ready", 32'(bus.in_ready), 32'd0);
    send(ADDI, 5'd1, 5'd2, 5'd0, 16'h7, 26'd0, 0);
    check_eq("hold_word", bus.instr, 32'h0800_0010);
    idle(1);
    check_eq("drain_jal", bus.instr, 32'h0FFF_FFFF);
    idle(1);

    do_reset();
    send(LB, 5'd3, 5'd2, 5'd0, 16'h1, 26'd0, 0);
`ifdef INSTR_ENCODER_BYTE_OPS_EN
    check_eq("lb_word", bus.instr, 32'h8062_0001);
`else
    check_eq("lb_err", 32'(bus.err), 32'd1);
    check_eq("lb_no_out", 32'(bus.out_valid), 32'd0);
    send(ADD, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 0);
    check_eq("after_lb_addr", bus.addr, 32'h0);
`endif

    do_reset();
    send(5'd31, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 0);
    send(SUB, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 0);
    send(OR, 5'd4, 5'd5, 5'd6, 16'd0, 26'd0, 0);
    step(1, ADD, 5'd1, 5'd1, 5'd1, 16'd0, 26'd0, 1, 1, 0);
    check_eq("flush_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("flush_err", 32'(bus.err), 32'd0);
    send(MFHI, 5'd7, 5'd7, 5'd9, 16'hFF, 26'd0, 0);
    check_eq("flush_addr", bus.addr, 32'h0);
    check_eq("mfhi_word", bus.instr, 32'h0000_4810);

    for (int i = 0; i < 600; i++) begin
      int r;
      logic [4:0] m;
      r = $urandom_range(0, 99);
      m = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 17));
      step($urandom_range(0, 3) != 0, m, 5'($urandom), 5'($urandom), 5'($urandom),
           16'($urandom), 26'($urandom), $urandom_range(0, 2) != 0, r < 5, r == 99);
    end

    @(negedge clk); reset2 = 1'b0;
    #1 check_eq("wrap_rst_addr", bus2.addr, 32'hFFFF_FFFC);
    bus2.in_valid = 1'b1; bus2.mnem = ADD;
    @(posedge clk); @(posedge clk); @(negedge clk);
    bus2.in_valid = 1'b0;
    check_eq("wrap_first_addr", bus2.addr, 32'hFFFF_FFFC);
    bus2.out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    check_eq("wrap_second_addr", bus2.addr, 32'h0000_0000);
    check_eq("wrap_valid", 32'(bus2.out_valid), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000: address of the first emitted instruction after reset or flush.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 flush  input  1  synchronous clear of buffer and address counter.
REQ-005 in_valid  input  1 / in_ready  output  1  field-level instruction handshake.
REQ-006 mnem  input  5  mnem_t: ADD, SUB, AND, OR, SLT, MFHI, MFLO, JR, LW, SW, BEQ, BNE, ADDI, J, JAL, SLTI, LB, SB.
REQ-007 rs, rt, rd  input  5 each  register fields.
REQ-008 imm  input  16  I-type immediate; target  input  26  J-type target.
REQ-009 out_valid  output  1 / out_ready  input  1  encoded-word handshake.
REQ-010 instr  output  32  encoded MIPS word; addr  output  32  byte address of instr.
REQ-011 err  output  1  sticky flag: unsupported mnemonic received.

Function
REQ-012 Transfer on in_valid&&in_ready (push) and on out_valid&&out_ready (pop).
REQ-013 Encodings: R-type op 000000, shamt 0, funct ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010, MFHI 010000, MFLO 010010, JR 001000.
REQ-014 Opcodes: LW 100011, LB 100000, SW 101011, SB 101000, BEQ 000100, BNE 000101, ADDI 001000, SLTI 001010, J 000010, JAL 000011.
REQ-015 Unused fields forced to zero: MFHI/MFLO keep rd only; JR keeps rs only; I-type uses rs,rt,imm; J-type uses target only.
REQ-016 Encoded words enter a 2-entry FIFO together with their address; instr/addr show the head entry.
REQ-017 Latency: word pushed in cycle N into an empty FIFO is visible with out_valid=1 in cycle N+1.
REQ-018 in_ready = (FIFO count < 2) && !flush; push and pop in the same cycle keep the count unchanged.
REQ-019 Address counter starts at BASE_ADDR, +4 per accepted valid word, wraps modulo 2^32.
REQ-020 Unsupported mnem (including out-of-range enum values): accepted (in_ready honoured), not stored, counter unchanged, err set to 1.
REQ-021 err stays 1 until reset or flush.
REQ-022 flush: FIFO emptied, counter := BASE_ADDR, err := 0 in next cycle; any push or pop in that cycle is discarded.
REQ-023 Head entry and out_valid hold stable while out_valid && !out_ready.

Reset
REQ-024 On reset: FIFO empty, out_valid=0, instr=0, addr=BASE_ADDR, err=0, in_ready=1 in the following cycle.
REQ-025 Reset mid-transfer discards all buffered words; reset takes priority over flush.

Configuration
REQ-026 Macro INSTR_ENCODER_BYTE_OPS_EN defined: LB and SB encode per REQ-014.
REQ-027 Macro INSTR_ENCODER_BYTE_OPS_EN undefined: LB and SB are unsupported and handled per REQ-020.

Structure
REQ-028 Package mipsenc_pkg holds mnem_t, the 6-bit opcode and funct constants, and the field-position constants.
REQ-029 Sub-module enc_fifo holds the 2-entry, 64-bit (instr+addr) FIFO with count, push, pop and clear.
REQ-030 Encoding logic is combinational ahead of the FIFO; it holds no state.

Verification
REQ-031 ADD rd=3 rs=1 rt=2 with out_ready=1 -> one cycle later instr=0x00221820, addr=0x0, out_valid=1.
REQ-032 LW rt=8 rs=29 imm=0x0004, then BEQ rs=4 rt=5 imm=0xFFFF -> 0x8FA80004 @0x0, then 0x1085FFFF @0x4.
REQ-033 out_ready=0 and three pushes (J target=0x10, JAL target=0x3FFFFFF, ADDI) -> in_ready=0 after two pushes; holding 0x08000010 on out; then out_ready=1 drains 0x08000010 and 0x0FFFFFFF in order.
REQ-034 LB without INSTR_ENCODER_BYTE_OPS_EN -> err=1, no output, next ADD gets addr=0x0; with the macro, LB rt=2 rs=3 imm=1 -> 0x80620001.
REQ-035 Two words buffered, then flush asserted with in_valid=1 -> out_valid=0, err=0, next accepted word gets addr=BASE_ADDR.
REQ-036 BASE_ADDR=0xFFFFFFFC and two pushes -> addrs 0xFFFFFFFC then 0x00000000.
